fifo_drain_ctrl: RTL

//  Read-side controller for the synchronous FIFO. Issues rd_en pops, absorbs the FIFO's 1-cycle read

---
 rtl/fifo_drain_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - FIFO read-side drain controller with 2-entry skid buffer and valid/ready output
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      beat_count,
    output logic                  underflow_err
);

    if (FIFO_DEPTH < 1) begin : g_depth_check
        $error("fifo_drain_ctrl: FIFO_DEPTH must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] buf0;
    logic [FIFO_WIDTH-1:0] buf1;
    logic                  pop;
    logic [2:0]            credit;

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign busy    = (state != IDLE);

    // Words held or already requested, net of the one leaving this cycle; a pop
    // implies occ >= 1, so the 3-bit subtraction cannot wrap.
    assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = (state == RUN) && enable && !fifo_empty && (credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            buf0          <= '0;
            buf1          <= '0;
            beat_count    <= '0;
            underflow_err <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop)
                beat_count <= beat_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (fifo_underflow)
                underflow_err <= 1'b1;

            case (state)
                IDLE: if (enable) state <= RUN;
                RUN:  if (!enable) state <= STOP;
                STOP: begin
                    if (enable)
                        state <= RUN;
                    else if (occ == 2'd0 && !inflight)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // buf0 is always the head; buf1 only ever holds the second word.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        buf0 <= fifo_data_out;
                    else
                        buf1 <= fifo_data_out;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_data_out;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
